bitscan_sequencer: RTL and testbench
====================================

# bitscan_sequencer

Sequencer around the 32-bit trailing-zero counter. It accepts a 32-bit bit mask as a job and emits the index of every set bit, one per cycle, lowest index first, over a valid/ready stream. Consumers are interrupt-pending scanning, register-list load/store expansion and similar bit-serial walks in the core. The block holds the pending-bit state, steers the trailing-zero datapath, and reports job completion with an emitted-index count.

## Interface
- `WIDTH`, 32, mask width; only 32 is supported, to match the trailing-zero datapath.
- `IDXW`, 5, index width; equals log2(`WIDTH`).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: job offer.
- `in_ready` output 1: block can accept a job; high exactly when in IDLE.
- `in_mask` input 32: job bit mask; sampled on accept.
- `in_base` input 5: scan start index; sampled on accept; used only with `BITSCAN_ROTATE_EN`.
- `abort` input 1: terminate the current job; honoured only in SCAN.
- `out_valid` output 1: `out_idx` is valid.
- `out_ready` input 1: consumer accepts `out_idx`.
- `out_idx` output 5: index of the next set bit.
- `out_last` output 1: `out_idx` is the final remaining set bit of the job.
- `done` output 1: one-cycle pulse at job end.
- `count` output 6: indices transferred in the last/current job (0..32).
- `aborted` output 1: last job ended via `abort`; valid with `done` and held until the next accept.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, SCAN, DONE. Registers: `pending[31:0]`, `base[4:0]`, `count`, `aborted`.
- IDLE, with `in_valid`: a job is accepted.
  - `pending <= in_mask`, `count <= 0`, `aborted <= 0`.
  - `base <= in_base` with the macro, otherwise 0.
  - If `in_mask == 0`, go to DONE; otherwise go to SCAN.
- SCAN drives the output stream.
  - `out_valid = 1`.
  - `out_idx = (ctz(rotr(pending, base)) + base) mod 32`, with 5-bit wrap. The datapath is combinational from `pending`.
  - `out_last = 1` when exactly one bit of `pending` is set (`pending & (pending-1) == 0`).
- Transfer (`out_valid & out_ready`): `pending[out_idx] <= 0`, `count <= count+1`. If `out_last` is set, go to DONE.
- `abort` in SCAN: go to DONE with `aborted <= 1`.
  - A transfer in the same cycle still takes effect (clear + count).
  - Abort wins over the `out_last` transition, but `aborted` is set only if `pending` was not emptied by that transfer.
- DONE: `done = 1` and `out_valid = 0`; the next state is always IDLE.
- `abort` outside SCAN is ignored.
- `out_idx` and `out_last` are don't-care when `out_valid = 0`; drive them as 0.
- Reset values: state IDLE, `pending = 0`, `base = 0`, `count = 0`, `aborted = 0`. Resulting outputs: `in_ready = 1`, `out_valid = 0`, `done = 0`, `busy = 0`, `out_idx = 0`, `out_last = 0`.
- Reset mid-job discards the job; no `done` pulse is produced.

## Timing
- Job accepted at cycle 0 produces the first `out_valid` at cycle 1.
- Throughput is one index per cycle while `out_ready` is held high.
- Job with N set bits and no backpressure:
  - indices at cycles 1..N;
  - `done` at cycle N+1;
  - `in_ready` at cycle N+2, so the next job is accepted at cycle N+2 at the earliest.
- Zero mask: `done` at cycle 1, `count = 0`, no `out_valid`.
- Backpressure: `out_idx` and `out_last` are held stable while `out_valid & !out_ready`. `out_valid` never drops in SCAN except via `abort`.
- `count` updates the cycle after each transfer. It is final when `done` is high and holds until the next accept.
- The critical path is `pending` → rotate → ctz → adder → `out_idx`. It must close in one cycle; no pipelining.

## Configuration
- `BITSCAN_ROTATE_EN`
  - Defined: `in_base` is latched. The scan starts at `base` and wraps past bit 31 to bit 0. Visit order is ascending from `base`, modulo 32. This provides round-robin fairness for arbitration users.
  - Undefined: `in_base` is ignored and `base` is fixed at 0. The rotator is removed and the scan order is strictly ascending from bit 0.

## Test plan
- `in_mask = 0x8000_0005`, `out_ready = 1` → `out_idx` 0, 2, 31 at cycles 1-3 with `out_last` only on 31; `done` at cycle 4 with `count = 3`, `aborted = 0`.
- `in_mask = 0` → no `out_valid`; `done` at cycle 1 with `count = 0`; `in_ready` at cycle 2.
- `in_mask = 0x30`, `out_ready` low for cycles 1-2 → `out_idx = 4` held stable through cycle 3; then 5 with `out_last`; `count = 2`.
- `in_mask = 0xFFFF_FFFF`, `abort` asserted with `out_ready` on the 4th transfer → `done` next cycle, `count = 4`, `aborted = 1`; single-bit mask with `abort` on its only transfer → `count = 1`, `aborted = 0`.
- `rst` asserted in SCAN after 2 transfers → next cycle `in_ready = 1`, `out_valid = 0`, `count = 0`, no `done`; a new job then runs normally.
- `in_mask = 0x11`, `in_base = 3` → with `BITSCAN_ROTATE_EN`: 4 then 0 (`out_last`). Without the macro: 0 then 4.

Source files
------------

// File: rtl/bitscan_sequencer.sv
// bitscan_sequencer: walks a 32-bit job mask and emits each set-bit index, lowest first, over valid/ready.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - job handshake; in_ready is high only in IDLE
//   in_mask, in_base   - job mask and scan start index (base used only with BITSCAN_ROTATE_EN)
//   abort              - terminate the current job, honoured only while scanning
//   out_valid/out_ready- index stream handshake
//   out_idx, out_last  - next set-bit index, and flag marking the final remaining bit
//   done               - one-cycle pulse at job end
//   count              - indices transferred in the last/current job
//   aborted            - last job ended via abort (held until the next accept)
//   busy               - sequencer not idle
//
// Optional feature macro: BITSCAN_ROTATE_EN enables a rotating start index for round-robin scans.
module bitscan_sequencer #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [IDXW-1:0]  in_base,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             done,
    output logic [IDXW:0]    count,
    output logic             aborted,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [IDXW-1:0]   base_q, base_d;
    logic [IDXW:0]     count_q, count_d;
    logic              aborted_q, aborted_d;

    logic [WIDTH-1:0]  rot;
    logic [IDXW-1:0]   tz;
    logic [IDXW-1:0]   scan_idx;
    logic              scan_last;
    logic              accept;
    logic              xfer;

`ifdef BITSCAN_ROTATE_EN
    logic [2*WIDTH-1:0] rot_wide;
    assign rot_wide = {pending_q, pending_q} >> base_q;
    assign rot      = rot_wide[WIDTH-1:0];
    assign base_d   = accept ? in_base : base_q;
`else
    logic unused_base;
    assign unused_base = ^in_base;
    assign rot         = pending_q;
    assign base_d      = '0;
`endif

    // Lowest set bit wins: scanning downward leaves the smallest index in tz.
    always_comb begin
        tz = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (rot[i]) tz = IDXW'(i);
    end

    assign scan_idx  = tz + base_q;
    assign scan_last = (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);
    assign accept    = (state_q == IDLE) && in_valid;
    assign xfer      = (state_q == SCAN) && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            base_q    <= '0;
            count_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            count_q   <= count_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? ((in_mask == '0) ? DONE : SCAN) : IDLE;
            SCAN:    state_d = (abort || (xfer && scan_last)) ? DONE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    // Datapath register updates
    always_comb begin
        pending_d = accept ? in_mask : xfer ? (pending_q & ~(WIDTH'(1) << scan_idx)) : pending_q;
        count_d   = accept ? '0 : xfer ? count_q + 1'b1 : count_q;
        // An abort that coincides with the final transfer is a normal completion.
        aborted_d = accept ? 1'b0 :
                    ((state_q == SCAN) && abort) ? !(xfer && scan_last) : aborted_q;
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == SCAN);
        done      = (state_q == DONE);
        out_idx   = (state_q == SCAN) ? scan_idx : '0;
        out_last  = (state_q == SCAN) ? scan_last : 1'b0;
        count     = count_q;
        aborted   = aborted_q;
    end

endmodule

// File: tb/tb_bitscan_sequencer.sv
// tb_bitscan_sequencer: directed vector bench for bitscan_sequencer.
module tb_bitscan_sequencer;

`ifdef BITSCAN_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mask;
    logic [4:0]  in_base;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        done;
    logic [5:0]  count;
    logic        aborted;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitscan_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_base(in_base),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
        .done(done), .count(count), .aborted(aborted), .busy(busy)
    );

    typedef struct {
        logic        iv;
        logic [31:0] mask;
        logic [4:0]  base;
        logic        ab;
        logic        ordy;
        logic        e_ov;
        logic [4:0]  e_idx;
        logic        e_last;
        logic        e_done;
        logic [5:0]  e_cnt;
        logic        e_irdy;
        logic        e_abt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic iv, logic [31:0] mask, logic [4:0] base, logic ab, logic ordy,
                               logic e_ov, logic [4:0] e_idx, logic e_last, logic e_done,
                               logic [5:0] e_cnt, logic e_irdy, logic e_abt);
        vec_t r;
        r.iv = iv; r.mask = mask; r.base = base; r.ab = ab; r.ordy = ordy;
        r.e_ov = e_ov; r.e_idx = e_idx; r.e_last = e_last; r.e_done = e_done;
        r.e_cnt = e_cnt; r.e_irdy = e_irdy; r.e_abt = e_abt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] mask, input logic [4:0] base,
                         input logic ab, input logic ordy);
        in_valid = iv; in_mask = mask; in_base = base; abort = ab; out_ready = ordy;
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [4:0] idx, input logic last,
                             input logic dn, input logic [5:0] cnt, input logic irdy, input logic abt);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_idx"},   32'(out_idx),   32'(idx));
        chk({tag, ".out_last"},  32'(out_last),  32'(last));
        chk({tag, ".done"},      32'(done),      32'(dn));
        chk({tag, ".count"},     32'(count),     32'(cnt));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(irdy));
        chk({tag, ".busy"},      32'(busy),      32'(!irdy));
        chk({tag, ".aborted"},   32'(aborted),   32'(abt));
    endtask

    initial begin
        // Job A: 0x8000_0005, no backpressure. Row 0 also checks the reset state.
        tbl.push_back(v(1, 32'h8000_0005, 0, 0, 1,  0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  2, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1, 31, 1, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 3, 0, 0));
        // Job B: zero mask
        tbl.push_back(v(1, 32'h0, 0, 0, 1,           0,  0, 0, 0, 3, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 0, 0, 1, 0));
        // Job C: 0x30 with backpressure on cycles 1-2
        tbl.push_back(v(1, 32'h30, 0, 0, 0,          0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,               1,  4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,               1,  4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  5, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 2, 0, 0));
        // Job D: all ones, abort on the 4th transfer
        tbl.push_back(v(1, 32'hFFFF_FFFF, 0, 0, 1,   0,  0, 0, 0, 2, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1,  2, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1,               1,  3, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 4, 0, 1));
        // Job E: single bit, abort on its only transfer
        tbl.push_back(v(1, 32'h100, 0, 0, 1,         0,  0, 0, 0, 4, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 1,               1,  8, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 1, 0, 0));
        // Job F: abort with no transfer
        tbl.push_back(v(1, 32'h6, 0, 0, 1,           0,  0, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,               1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 0, 0, 1));
        // Abort in IDLE is ignored
        tbl.push_back(v(0, 0, 0, 1, 1,               0,  0, 0, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 0, 0, 1, 1));
        // Job G: 0x11 with base 3; order depends on the rotate build
        tbl.push_back(v(1, 32'h11, 3, 0, 1,          0,  0, 0, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1,               1, ROT ? 5'd4 : 5'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               1, ROT ? 5'd0 : 5'd4, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 1, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,               0,  0, 0, 0, 2, 1, 0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].mask, tbl[i].base, tbl[i].ab, tbl[i].ordy);
            #1;
            chk_state($sformatf("row%0d", i), tbl[i].e_ov, tbl[i].e_idx, tbl[i].e_last,
                      tbl[i].e_done, tbl[i].e_cnt, tbl[i].e_irdy, tbl[i].e_abt);
        end

        // Reset mid-job after two transfers
        @(negedge clk); drive(1, 32'hF, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 1); #1 chk("mid.idx0", 32'(out_idx), 0);
        @(negedge clk); #1 chk("mid.idx1", 32'(out_idx), 1);
        @(negedge clk); rst = 1'b1; #1 chk_state("mid.pre", 1, 2, 0, 0, 2, 0, 0);
        @(negedge clk); rst = 1'b0; #1 chk_state("mid.rst", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); #1 chk_state("mid.idle", 0, 0, 0, 0, 0, 1, 0);

        // New job after reset runs normally; bounded wait for done
        drive(1, 32'h3, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 1); #1 chk_state("post.c1", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1 chk_state("post.c2", 1, 1, 1, 0, 1, 0, 0);
        begin
            int n = 0;
            while (!done && n < 10) begin
                @(negedge clk); #1;
                n++;
            end
            chk("post.done_seen", 32'(done), 1);
            chk("post.done_lat", 32'(n), 1);
            chk("post.count", 32'(count), 2);
            chk("post.aborted", 32'(aborted), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
